sipo_rx_ctrl: RTL
=================

// Module: sipo_rx_ctrl
// PURPOSE
//  Sequencer for the 10-bit serial-in/parallel-out shift register on the serial receive path.
//  Detects a start bit on the async serial line and pulses the SIPO shift at each bit centre.
//  After 10 shifts (start, 8 data LSB-first, stop) it checks framing and unpacks the SIPO word.
//  The data byte is delivered to the consumer with a valid/ready handshake; overrun is flagged.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per serial bit; legal range 4..4095.
//  FRAME_BITS    10  total shifts per frame; fixed at 10 (must match the SIPO width).
// PORTS
//  clk          in   1   system clock; all logic is on its rising edge.
//  reset        in   1   synchronous, active-high reset.
//  serial_in    in   1   async serial line; idle level is 1.
//  sipo_shift   out  1   1-cycle pulse; the SIPO shifts on the clk edge where this is high.
//  sipo_din     out  1   synchronised sampled bit, fed to SIPO data_in.
//  sipo_q       in   10  SIPO parallel output (Q[0] = newest bit).
//  rx_data      out  8   received byte.
//  rx_valid     out  1   rx_data valid; held until accepted.
//  rx_ready     in   1   consumer accepts the byte when rx_valid and rx_ready are both 1.
//  framing_err  out  1   1-cycle pulse on a bad start or stop bit in a completed frame.
//  overrun      out  1   sticky; a frame completed while rx_valid was still pending.
//  busy         out  1   1 in any state other than IDLE.
// BEHAVIOUR
//  Reset: state=IDLE; all counters=0; sipo_shift=0, sipo_din=1, rx_data=0, rx_valid=0,
//   framing_err=0, overrun=0, busy=0. Reset wins over every other event, including mid-frame.
//  Synchroniser: 2 flops on serial_in, reset to 1. All logic uses only the synchronised bit `rxs`.
//   sipo_din = rxs at all times.
//  Counter widths: clk counter is $clog2(CLKS_PER_BIT) bits; bit counter is 4 bits.
//  FSM:
//   IDLE:  rxs==0 -> START, clk_cnt=0.
//   START: clk_cnt counts up. At clk_cnt==CLKS_PER_BIT/2-1 the start bit is sampled:
//          if rxs==0, pulse sipo_shift, set bit_cnt=1, clk_cnt=0 -> SHIFT;
//          if rxs==1 (glitch), no shift -> IDLE.
//   SHIFT: at clk_cnt==CLKS_PER_BIT-1, pulse sipo_shift, bit_cnt++, clk_cnt=0.
//          The pulse with bit_cnt==9 (the 10th shift, stop bit) -> DONE.
//   DONE:  lasts exactly 1 cycle and reads the sipo_q value updated by the last shift. -> IDLE.
//  Frame layout in DONE: sipo_q[9]=start, sipo_q[8]=d0 ... sipo_q[1]=d7, sipo_q[0]=stop.
//   So rx_data[i] = sipo_q[8-i].
//  Frame check in DONE:
//   good = sipo_q[9]==0 && sipo_q[0]==1.
//   If !good: framing_err=1 for the next cycle; rx_data, rx_valid and overrun are unchanged.
//   If good && (!rx_valid || rx_ready): rx_data is loaded and rx_valid=1 from the next cycle.
//   If good && rx_valid && !rx_ready: overrun=1 (sticky until reset); the new byte is dropped
//    and rx_data keeps the old byte.
//  Latency: the 10th sipo_shift pulse is at cycle t; DONE is t+1; rx_valid/framing_err appear at t+2.
//  Handshake: rx_valid falls the cycle after rx_valid && rx_ready. A DONE load in that same
//   cycle takes priority, and rx_valid stays 1 with the new byte.
//  Exactly 10 sipo_shift pulses are issued per accepted start bit, and none are issued in IDLE.
//  busy=1 in START, SHIFT and DONE.
//  A new start bit is only detected once back in IDLE (the first cycle after DONE).
// TESTING (CLKS_PER_BIT=16, 8N1 stimulus, SIPO model instantiated)
//  1. Assert reset for 3 cycles with serial_in=0 -> every output at its reset value;
//     no sipo_shift pulses until reset is released.
//  2. Send byte 0xA5, rx_ready=1 -> exactly 10 shifts, 16 cycles apart; sipo_q=10'b0_10100101_1;
//     rx_data=0xA5 with rx_valid high for 1 cycle; framing_err=0.
//  3. Drive serial_in low for 4 cycles, then high -> no sipo_shift pulse, busy returns to 0,
//     rx_valid stays 0.
//  4. Send 0x3C with stop bit=0 -> framing_err pulses for 1 cycle; rx_valid stays 0;
//     overrun stays 0.
//  5. Send 0x11 then 0x22 with rx_ready=0 -> overrun=1 after the 2nd frame; rx_data=0x11.
//     Then set rx_ready=1 -> rx_valid drops; overrun stays 1.
//  6. Assert reset after the 5th shift of a frame, then send 0x7E -> only 0x7E is delivered,
//     with exactly 10 shifts after reset.

Source files
------------

// File: rtl/sipo_rx_ctrl.sv
// Receive sequencer for a 10-bit SIPO: start detection, bit-centre shift pulses,
// framing check and valid/ready delivery of the unpacked byte.
module sipo_rx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FRAME_BITS   = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serial_in,
  output logic                  sipo_shift,
  output logic                  sipo_din,
  input  logic [FRAME_BITS-1:0] sipo_q,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  framing_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       BIT_END = 4'(FRAME_BITS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [3:0]       r_bit_cnt;
  logic             r_shift;
  logic [7:0]       r_rx_data;
  logic             r_rx_valid;
  logic             r_ferr;
  logic             r_overrun;
  logic             r_busy;

  logic [7:0]       w_data;
  logic             w_good;

  // Start bit is the oldest SIPO bit, stop bit the newest; data arrived LSB first.
  assign w_data = {sipo_q[1], sipo_q[2], sipo_q[3], sipo_q[4],
                   sipo_q[5], sipo_q[6], sipo_q[7], sipo_q[8]};
  assign w_good = !sipo_q[FRAME_BITS-1] && sipo_q[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_clk_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_ferr     <= 1'b0;
      r_overrun  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_sync1 <= serial_in;
      r_sync2 <= r_sync1;
      r_shift <= 1'b0;
      r_ferr  <= 1'b0;
      if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (!r_sync2) begin
            r_state   <= ST_START;
            r_clk_cnt <= '0;
            r_busy    <= 1'b1;
          end
        end

        // Re-check the line at mid start bit to reject glitches.
        ST_START: begin
          if (r_clk_cnt == HALF_M1) begin
            r_clk_cnt <= '0;
            if (!r_sync2) begin
              r_shift   <= 1'b1;
              r_bit_cnt <= 4'd1;
              r_state   <= ST_SHIFT;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end

        // Wait one cycle after the final pulse so DONE sees the updated SIPO word.
        ST_SHIFT: begin
          if (r_bit_cnt == BIT_END) begin
            r_state <= ST_DONE;
          end else if (r_clk_cnt == LAST) begin
            r_shift   <= 1'b1;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            r_clk_cnt <= '0;
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end

        ST_DONE: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_bit_cnt <= '0;
          r_clk_cnt <= '0;
          if (!w_good) begin
            r_ferr <= 1'b1;
          end else if (!r_rx_valid || rx_ready) begin
            r_rx_data  <= w_data;
            r_rx_valid <= 1'b1;
          end else begin
            r_overrun <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sipo_shift  = r_shift;
  assign sipo_din    = r_sync2;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign framing_err = r_ferr;
  assign overrun     = r_overrun;
  assign busy        = r_busy;

endmodule
